// File: rtl/c_scale_pkg.sv
`default_nettype none
// ============================================================================
// Package     : c_scale_pkg
// Description : Note-select codes, code validity check and sequencer states
//               shared by key_reader, note_sequencer and c_scale.
// Revision    : 1.0 - initial release
// ============================================================================
package c_scale_pkg;

    localparam int TIMER_W = 27;

    localparam logic [4:0] NOTE_REST      = 5'd0;
    localparam logic [4:0] NOTE_C         = 5'd1;
    localparam logic [4:0] NOTE_CS        = 5'd2;
    localparam logic [4:0] NOTE_D         = 5'd3;
    localparam logic [4:0] NOTE_DS        = 5'd4;
    localparam logic [4:0] NOTE_E         = 5'd5;
    localparam logic [4:0] NOTE_F         = 5'd7;
    localparam logic [4:0] NOTE_FS        = 5'd8;
    localparam logic [4:0] NOTE_G         = 5'd9;
    localparam logic [4:0] NOTE_GS        = 5'd10;
    localparam logic [4:0] NOTE_A         = 5'd11;
    localparam logic [4:0] NOTE_AS        = 5'd12;
    localparam logic [4:0] NOTE_B         = 5'd13;
    localparam logic [4:0] NOTE_C2        = 5'd15;
    localparam logic [4:0] NOTE_MAJ_SEC   = 5'd16;
    localparam logic [4:0] NOTE_MAJ_THIRD = 5'd17;
    localparam logic [4:0] NOTE_FOURTH    = 5'd18;
    localparam logic [4:0] NOTE_FIFTH     = 5'd19;
    localparam logic [4:0] NOTE_MAJ_SIXTH = 5'd20;
    localparam logic [4:0] NOTE_OCTAVE    = 5'd21;
    localparam logic [4:0] NOTE_D2        = 5'd22;

    // Codes 6, 14 and 23-31 have no note behind them and behave as "no key".
    function automatic logic valid_code(input logic [4:0] code);
        return (code >= 5'd1) && (code <= 5'd22) && (code != 5'd6) && (code != 5'd14);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LIVE = 3'd1,
        ST_NOTE = 3'd2,
        ST_GAP  = 3'd3,
        ST_HOLD = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/note_sequencer_melody_rom.sv
`default_nettype none
// ============================================================================
// Module      : melody_rom
// Description : 16-entry demo melody, asynchronous read. Entry 15 is a rest.
// Revision    : 1.0 - initial release
// ============================================================================
module melody_rom
    import c_scale_pkg::*;
(
    input  logic [3:0] i_addr,
    output logic [4:0] o_code
);

    // Rising then falling scale run, ending on a rest before the loop restarts.
    always_comb begin
        o_code = NOTE_REST;
        case (i_addr)
            4'd0:    o_code = NOTE_C;
            4'd1:    o_code = NOTE_D;
            4'd2:    o_code = NOTE_E;
            4'd3:    o_code = NOTE_F;
            4'd4:    o_code = NOTE_G;
            4'd5:    o_code = NOTE_A;
            4'd6:    o_code = NOTE_B;
            4'd7:    o_code = NOTE_C2;
            4'd8:    o_code = NOTE_B;
            4'd9:    o_code = NOTE_A;
            4'd10:   o_code = NOTE_G;
            4'd11:   o_code = NOTE_F;
            4'd12:   o_code = NOTE_E;
            4'd13:   o_code = NOTE_D;
            4'd14:   o_code = NOTE_C;
            default: o_code = NOTE_REST;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : note_sequencer
// Description : Chooses the note-select code: live key codes always win,
//               otherwise a built-in demo melody is stepped at a selectable
//               tempo with a silent gap at the end of each step.
// Revision    : 1.0 - initial release
// ============================================================================
module note_sequencer
    import c_scale_pkg::*;
#(
    parameter int BASE_TICKS = 6_250_000,
    parameter int GAP_TICKS  = 625_000,
    parameter int SEQ_LEN    = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [4:0] key_code,
    input  logic       play_en,
    input  logic [1:0] tempo_sel,
    output logic [4:0] note_code,
    output logic       demo_active,
    output logic [3:0] step_idx,
    output logic       step_strobe
);

    localparam logic [TIMER_W-1:0] c_base = TIMER_W'(BASE_TICKS);
    localparam logic [TIMER_W-1:0] c_gap  = TIMER_W'(GAP_TICKS);
    localparam logic [3:0]         c_last = 4'(SEQ_LEN - 1);

    seq_state_t         r_state;
    seq_state_t         w_next_state;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_next;
    logic [TIMER_W-1:0] w_note_load;
    logic [3:0]         w_idx_next;
    logic [4:0]         w_rom_code;
    logic [4:0]         w_note_next;
    logic               w_strobe_next;
    logic               w_key_valid;
    logic               w_expired;

    // The ROM is read at the index that will be current after this edge, so
    // note_code changes in the same cycle as the state it belongs to.
    melody_rom u_rom (
        .i_addr (w_idx_next),
        .o_code (w_rom_code)
    );

    // Next-state, timer reload and step-index decisions; key beats play_en beats timer.
    always_comb begin
        w_next_state  = r_state;
        w_timer_next  = r_timer;
        w_idx_next    = step_idx;
        w_strobe_next = 1'b0;
        w_key_valid   = valid_code(key_code);
        w_expired     = (r_timer == TIMER_W'(1));
        // Audible part of a step; tempo_sel is sampled only here, at NOTE entry.
        w_note_load   = (c_base << (2'd3 - tempo_sel)) - c_gap;

        case (r_state)
            ST_IDLE: begin
                w_timer_next = '0;
                if (w_key_valid) begin
                    w_next_state = ST_LIVE;
                end else if (play_en) begin
                    w_next_state  = ST_NOTE;
                    w_timer_next  = w_note_load;
                    w_strobe_next = 1'b1;
                end
            end
            ST_LIVE: begin
                w_timer_next = '0;
                if (!w_key_valid) begin
                    if (play_en) begin
                        w_next_state = ST_HOLD;
                        w_timer_next = c_gap;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_NOTE, ST_GAP, ST_HOLD: begin
                if (w_key_valid) begin
                    w_next_state = ST_LIVE;
                    w_timer_next = '0;
                end else if (!play_en) begin
                    w_next_state = ST_IDLE;
                    w_timer_next = '0;
                    w_idx_next   = '0;
                end else if (!w_expired) begin
                    w_timer_next = r_timer - TIMER_W'(1);
                end else if (r_state == ST_NOTE) begin
                    w_next_state = ST_GAP;
                    w_timer_next = c_gap;
                end else begin
                    // GAP advances to the next step; HOLD replays the same one.
                    if (r_state == ST_GAP) begin
                        w_idx_next = (step_idx == c_last) ? 4'd0 : step_idx + 4'd1;
                    end
                    w_next_state  = ST_NOTE;
                    w_timer_next  = w_note_load;
                    w_strobe_next = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_timer_next = '0;
            end
        endcase

        case (w_next_state)
            ST_LIVE: w_note_next = key_code;
            ST_NOTE: w_note_next = w_rom_code;
            default: w_note_next = NOTE_REST;
        endcase
    end

    // State, timer and all outputs update together so nothing is ever half-stepped.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            step_idx    <= '0;
            note_code   <= NOTE_REST;
            demo_active <= 1'b0;
            step_strobe <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_timer     <= w_timer_next;
            step_idx    <= w_idx_next;
            note_code   <= w_note_next;
            demo_active <= (w_next_state == ST_NOTE) || (w_next_state == ST_GAP);
            step_strobe <= w_strobe_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_sequencer
// Description : Directed bench for note_sequencer with short tick counts
//               (8-clock base step, 2-clock gap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_sequencer;

    logic       clk;
    logic       rst;
    logic [4:0] r_key;
    logic       r_play;
    logic [1:0] r_tempo;
    logic [4:0] w_note;
    logic       w_demo;
    logic [3:0] w_idx;
    logic       w_strobe;

    int n_vec = 0;
    int n_err = 0;

    note_sequencer #(
        .BASE_TICKS (8),
        .GAP_TICKS  (2),
        .SEQ_LEN    (16)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (rst),
        .key_code    (r_key),
        .play_en     (r_play),
        .tempo_sel   (r_tempo),
        .note_code   (w_note),
        .demo_active (w_demo),
        .step_idx    (w_idx),
        .step_strobe (w_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; r_key = 5'd0; r_play = 1'b0; r_tempo = 2'b11;
        step(2);
        chk("rst_note", w_note, 0);
        chk("rst_demo", w_demo, 0);
        chk("rst_idx", w_idx, 0);
        chk("rst_strobe", w_strobe, 0);
        rst = 1'b0;
        step(1);

        // Live key from IDLE, then release with demo off.
        r_key = 5'd9;
        step(1);
        chk("live_note", w_note, 9);
        chk("live_demo", w_demo, 0);
        r_key = 5'd0;
        step(1);
        chk("release_note", w_note, 0);

        // Demo start: 6 clocks of note, 2 of gap, then step 1.
        r_play = 1'b1;
        step(1);
        chk("s0_strobe", w_strobe, 1);
        chk("s0_note", w_note, 1);
        chk("s0_idx", w_idx, 0);
        chk("s0_demo", w_demo, 1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("s0_hold", w_note, 1);
            chk("s0_nostrobe", w_strobe, 0);
        end
        step(1);
        chk("s0_gap1", w_note, 0);
        chk("s0_gap1_demo", w_demo, 1);
        step(1);
        chk("s0_gap2", w_note, 0);
        step(1);
        chk("s1_strobe", w_strobe, 1);
        chk("s1_idx", w_idx, 1);
        chk("s1_note", w_note, 3);

        // Step 15 is a rest for the full 8 clocks, then wrap to step 0.
        step(8 * 14);
        chk("s15_idx", w_idx, 15);
        chk("s15_strobe", w_strobe, 1);
        chk("s15_note", w_note, 0);
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("s15_silent", w_note, 0);
        end
        step(1);
        chk("wrap_idx", w_idx, 0);
        chk("wrap_note", w_note, 1);
        chk("wrap_strobe", w_strobe, 1);

        // Live preemption at step 4, then HOLD and a full replay of step 4.
        step(8 * 4);
        chk("s4_note", w_note, 9);
        step(2);
        r_key = 5'd19;
        step(1);
        chk("pre_note", w_note, 19);
        chk("pre_idx", w_idx, 4);
        chk("pre_demo", w_demo, 0);
        r_key = 5'd20;
        step(1);
        chk("pre_track", w_note, 20);
        r_key = 5'd0;
        step(1);
        chk("hold1", w_note, 0);
        chk("hold1_demo", w_demo, 0);
        step(1);
        chk("hold2", w_note, 0);
        step(1);
        chk("replay_strobe", w_strobe, 1);
        chk("replay_idx", w_idx, 4);
        chk("replay_note", w_note, 9);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("replay_hold", w_note, 9);
        end
        step(1);
        chk("replay_gap", w_note, 0);

        // Tempo change mid-step applies only from the next step.
        step(2);
        chk("s5_note", w_note, 11);
        chk("s5_idx", w_idx, 5);
        step(2);
        r_tempo = 2'b00;
        step(3);
        chk("s5_last", w_note, 11);
        step(1);
        chk("s5_gap", w_note, 0);
        step(2);
        chk("s6_strobe", w_strobe, 1);
        chk("s6_note", w_note, 13);
        step(61);
        chk("s6_c62", w_note, 13);
        step(1);
        chk("s6_gap", w_note, 0);
        chk("s6_gap_demo", w_demo, 1);

        // Invalid codes are ignored; play_en drop in GAP returns to IDLE.
        r_key = 5'd6;
        step(1);
        chk("inv6_note", w_note, 0);
        chk("inv6_demo", w_demo, 1);
        r_key = 5'd23;
        r_play = 1'b0;
        step(1);
        chk("drop_note", w_note, 0);
        chk("drop_demo", w_demo, 0);
        chk("drop_idx", w_idx, 0);
        step(1);
        chk("inv23_idle", w_note, 0);
        r_key = 5'd0;

        // Reset asserted mid-NOTE clears everything on the next edge.
        r_tempo = 2'b11;
        r_play = 1'b1;
        step(1);
        chk("restart_note", w_note, 1);
        step(8 + 2);
        chk("mid_idx", w_idx, 1);
        rst = 1'b1;
        step(1);
        chk("mrst_note", w_note, 0);
        chk("mrst_demo", w_demo, 0);
        chk("mrst_idx", w_idx, 0);
        chk("mrst_strobe", w_strobe, 0);
        rst = 1'b0;
        r_play = 1'b0;
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
